// File: rtl/bin2bcd_4dig.sv
// Sequential double-dabble converter: unsigned binary in, four BCD digits out.
// Results are held between conversions and replaced only when a conversion completes.
module bin2bcd_4dig #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       dig1,
    output logic [3:0]       dig2,
    output logic [3:0]       dig3,
    output logic [3:0]       dig4
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [BIN_W-1:0] r_shreg;
    logic [15:0]      r_scratch;
    logic [3:0]       r_cnt;
    logic             r_ovf_pend;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;
    logic [3:0]       r_dig1;
    logic [3:0]       r_dig2;
    logic [3:0]       r_dig3;
    logic [3:0]       r_dig4;

    logic [15:0]      w_adj;
    logic [15:0]      w_scratch_next;
    logic             w_ovf_in;

    // Each nibble is corrected independently before the shift; no inter-nibble carry.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_add3
            assign w_adj[gi*4 +: 4] = (r_scratch[gi*4 +: 4] >= 4'd5)
                                      ? r_scratch[gi*4 +: 4] + 4'd3
                                      : r_scratch[gi*4 +: 4];
        end
    endgenerate

    assign w_scratch_next = {w_adj[14:0], r_shreg[BIN_W-1]};
    assign w_ovf_in       = ({{(32-BIN_W){1'b0}}, bin} > 32'd9999);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_dig1     <= '0;
            r_dig2     <= '0;
            r_dig3     <= '0;
            r_dig4     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shreg    <= bin;
                        r_scratch  <= '0;
                        r_cnt      <= 4'(BIN_W);
                        r_ovf_pend <= w_ovf_in;
                        r_busy     <= 1'b1;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_scratch <= w_scratch_next;
                    r_shreg   <= r_shreg << 1;
                    r_cnt     <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        // Out-of-range inputs saturate the display rather than wrap.
                        if (r_ovf_pend) begin
                            r_dig1 <= 4'd9;
                            r_dig2 <= 4'd9;
                            r_dig3 <= 4'd9;
                            r_dig4 <= 4'd9;
                        end else begin
                            r_dig1 <= w_scratch_next[15:12];
                            r_dig2 <= w_scratch_next[11:8];
                            r_dig3 <= w_scratch_next[7:4];
                            r_dig4 <= w_scratch_next[3:0];
                        end
                        r_ovf   <= r_ovf_pend;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign ovf  = r_ovf;
    assign dig1 = r_dig1;
    assign dig2 = r_dig2;
    assign dig3 = r_dig3;
    assign dig4 = r_dig4;

endmodule

// File: tb/tb_bin2bcd_4dig.sv
// Self-checking bench for bin2bcd_4dig: directed table, timing corner cases,
// back-to-back starts, mid-conversion reset and random values vs. an arithmetic model.
module tb_bin2bcd_4dig;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [3:0]  dig1;
    logic [3:0]  dig2;
    logic [3:0]  dig3;
    logic [3:0]  dig4;

    int n_total = 0;
    int n_pass  = 0;

    bin2bcd_4dig #(.BIN_W(14)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .dig1  (dig1),
        .dig2  (dig2),
        .dig3  (dig3),
        .dig4  (dig4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          value;
        logic [16:0] exp_word;
    } vec_t;

    // Expected word is {ovf, d1, d2, d3, d4}: hex digits read as the decimal display.
    function automatic logic [16:0] ref_word(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {(v > 9999), 4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic [16:0] out_word();
        return {ovf, dig1, dig2, dig3, dig4};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One start pulse, wait for done, check latency, result and return to idle.
    task automatic conv(input int value, input logic [16:0] exp_word, input string tag);
        int   lat;
        logic got;
        start = 1'b1;
        bin   = 14'(value);
        @(negedge clk);
        start = 1'b0;
        bin   = 14'($urandom);
        check({tag, "_busy"}, int'(busy), 1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (done) got = 1'b1;
        end
        check({tag, "_latency"}, lat, 14);
        check({tag, "_result"}, int'(out_word()), int'(exp_word));
        $display("conv %-8s bin=%0d -> %0d%0d%0d%0d ovf=%0d lat=%0d",
                 tag, value, dig1, dig2, dig3, dig4, ovf, lat);
        @(negedge clk);
        check({tag, "_idle"}, int'({busy, done}), 0);
    endtask

    vec_t tbl[12];

    initial begin
        int hist[100];
        int n_done;
        int last_done;
        int v;

        tbl[0]  = '{0,     17'h00000};
        tbl[1]  = '{9999,  17'h09999};
        tbl[2]  = '{10000, 17'h19999};
        tbl[3]  = '{16383, 17'h19999};
        tbl[4]  = '{1234,  17'h01234};
        tbl[5]  = '{1,     17'h00001};
        tbl[6]  = '{10,    17'h00010};
        tbl[7]  = '{100,   17'h00100};
        tbl[8]  = '{1000,  17'h01000};
        tbl[9]  = '{999,   17'h00999};
        tbl[10] = '{5555,  17'h05555};
        tbl[11] = '{8086,  17'h08086};

        // Reset held with start asserted: outputs stay at reset values.
        rst   = 1'b0;
        start = 1'b1;
        bin   = 14'd1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs", int'({busy, done, out_word()}), 0);
        end
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        check("post_reset_idle", int'({busy, done, out_word()}), 0);

        for (int i = 0; i < 12; i++)
            conv(tbl[i].value, tbl[i].exp_word, "table");

        // Start held high with bin changing every cycle.
        n_done    = 0;
        last_done = -1;
        for (int k = 0; k < 100; k++) begin
            if (done) begin
                n_done++;
                check("held_result", int'(out_word()), int'(ref_word(hist[k-15])));
                if (last_done >= 0) check("held_spacing", k - last_done, 16);
                $display("held done at cycle %0d bin=%0d -> %0d%0d%0d%0d ovf=%0d",
                         k, hist[k-15], dig1, dig2, dig3, dig4, ovf);
                last_done = k;
            end
            start   = 1'b1;
            v       = int'($urandom_range(0, 16383));
            bin     = 14'(v);
            hist[k] = v;
            @(negedge clk);
        end
        start = 1'b0;
        check("held_done_count", n_done, 6);
        repeat (20) @(negedge clk);

        // Reset during the 7th shift cycle aborts without a done pulse.
        conv(4321, 17'h04321, "pre_abort");
        start = 1'b1;
        bin   = 14'd5678;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_async_clear", int'({busy, done, out_word()}), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", int'({busy, done, out_word()}), 0);
        end
        rst = 1'b1;
        @(negedge clk);
        conv(42, 17'h00042, "after_rst");

        for (int i = 0; i < 250; i++) begin
            v = (i < 6) ? (9997 + i) : int'($urandom_range(0, 16383));
            conv(v, ref_word(v), "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
